// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: one imem request/response per start, then PC advance or redirect.
// Optional fetch watchdog is compiled in by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl #(
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   pc_en,
    output logic [PC_WIDTH-1:0]    next_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_redir_vld;
    logic [PC_WIDTH-1:0]    r_redir_tgt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   w_complete;
    logic                   w_latch_redir;
    logic                   w_timeout;
    logic                   w_abort;

    if (FETCH_TIMEOUT == 0) begin : g_param_chk
        $error("FETCH_TIMEOUT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Watchdog fires in the FETCH_TIMEOUT-th busy cycle (counter starts at 0 in REQ).
    assign w_timeout = (r_state != S_IDLE) && (r_cnt == CNT_W'(FETCH_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and PC update; a response landing in WAIT always beats the watchdog.
    always_comb begin
        w_state_nxt   = r_state;
        pc_en         = 1'b0;
        next_pc       = pc + PC_WIDTH'(4);
        w_complete    = 1'b0;
        w_latch_redir = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (branch_taken) begin
                    pc_en   = rst_n;
                    next_pc = branch_target;
                end else if (start) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_latch_redir = branch_taken;
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_latch_redir = branch_taken;
                if (imem_rsp_valid) begin
                    w_complete  = 1'b1;
                    pc_en       = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (branch_taken) begin
                        next_pc = branch_target;
                    end else if (r_redir_vld) begin
                        next_pc = r_redir_tgt;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_timeout && !w_complete) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    // Pending redirect: last request wins, consumed by completion, kept across a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redir_vld <= 1'b0;
            r_redir_tgt <= '0;
        end else if (w_complete) begin
            r_redir_vld <= 1'b0;
            r_redir_tgt <= '0;
        end else if (w_latch_redir) begin
            r_redir_vld <= 1'b1;
            r_redir_tgt <= branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
        end else if (w_complete) begin
            r_instr <= imem_rsp_data;
        end
    end

    // Fetched word is presented in the completion cycle so it lines up with instr_valid.
    assign instr          = w_complete ? imem_rsp_data : r_instr;
    assign instr_valid    = w_complete;
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_addr      = pc;
    assign busy           = (r_state != S_IDLE);
    assign fetch_err      = w_abort;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl; the bench also models the PC register fed by pc_en/next_pc.
module tb_pc_fetch_ctrl;

    localparam int unsigned PW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          branch_taken = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic [PW-1:0] pc = '0;
    logic          pc_en;
    logic [PW-1:0] next_pc;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [PW-1:0] imem_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          busy;
    logic          fetch_err;

    logic          pc_load = 1'b0;
    logic [PW-1:0] pc_load_val = '0;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PW-1:0] npc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic          c_iv, c_pe;
    logic [IW-1:0] c_instr;
    logic [PW-1:0] c_npc;

    pc_fetch_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc(pc), .pc_en(pc_en), .next_pc(next_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .instr(instr),
        .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // PC register driven by the DUT, with a bench-side load port for test setup
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (pc_en) pc <= next_pc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [PW-1:0] v);
        pc_load = 1'b1; pc_load_val = v;
        tick();
        pc_load = 1'b0;
    endtask

    // Issues start and an immediate request handshake; returns in the first WAIT cycle
    task automatic start_fetch();
        start = 1'b1;
        tick();
        start = 1'b0; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    // Drives one response beat and captures the completion-cycle outputs
    task automatic capture(input logic [IW-1:0] d);
        imem_rsp_valid = 1'b1; imem_rsp_data = d;
        @(negedge clk);
        c_iv = instr_valid; c_pe = pc_en; c_instr = instr; c_npc = next_pc;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0ABC;
        set_pc(32'h0000_1234);
        @(negedge clk);
        n_tests++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en got %b exp 0", pc_en); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_err got %b exp 0", fetch_err); end
        n_tests++; if (imem_addr !== 32'h0000_1234) begin n_fail++; $display("FAIL rst_imem_addr got %h exp 00001234", imem_addr); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", instr); end
        start = 1'b0; branch_taken = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        set_pc(32'h0000_0100);
        start = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
        tick();
        start = 1'b0; imem_req_ready = 1'b1;
        sb.push_back('{instr: 32'h8C22_0004, npc: 32'h0000_0104});
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid got %b exp 1", imem_req_valid); end
        n_tests++; if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL basic_addr got %h exp 00000100", imem_addr); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        n_tests++; if ({pc_en, instr_valid, imem_req_valid} !== 3'b000) begin n_fail++; $display("FAIL basic_wait_quiet got %b exp 000", {pc_en, instr_valid, imem_req_valid}); end
        tick();
        capture(32'h8C22_0004);
        e = sb.pop_front();
        n_tests++; if ({c_iv, c_pe} !== 2'b11) begin n_fail++; $display("FAIL basic_pulses got %b exp 11", {c_iv, c_pe}); end
        n_tests++; if (c_instr !== e.instr) begin n_fail++; $display("FAIL basic_instr got %h exp %h", c_instr, e.instr); end
        n_tests++; if (c_npc !== e.npc) begin n_fail++; $display("FAIL basic_next_pc got %h exp %h", c_npc, e.npc); end
        @(negedge clk);
        n_tests++; if ({busy, instr_valid, pc_en} !== 3'b000) begin n_fail++; $display("FAIL basic_after got %b exp 000", {busy, instr_valid, pc_en}); end
        n_tests++; if (instr !== 32'h8C22_0004) begin n_fail++; $display("FAIL basic_instr_hold got %h exp 8c220004", instr); end
        n_tests++; if (pc !== 32'h0000_0104) begin n_fail++; $display("FAIL basic_pc_reg got %h exp 00000104", pc); end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        sb.push_back('{instr: 32'hA5A5_0001, npc: 32'h0000_0000});
        start_fetch();
        capture(32'hA5A5_0001);
        e = sb.pop_front();
        n_tests++; if (c_npc !== e.npc) begin n_fail++; $display("FAIL wrap_next_pc got %h exp %h", c_npc, e.npc); end
        n_tests++; if (c_instr !== e.instr) begin n_fail++; $display("FAIL wrap_instr got %h exp %h", c_instr, e.instr); end
    endtask

    task automatic test_idle_branch();
        set_pc(32'h0000_0500);
        start = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_0020;
        @(negedge clk);
        n_tests++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL ibr_pc_en got %b exp 1", pc_en); end
        n_tests++; if (next_pc !== 32'h0040_0020) begin n_fail++; $display("FAIL ibr_next_pc got %h exp 00400020", next_pc); end
        n_tests++; if ({busy, imem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL ibr_same_cycle got %b exp 00", {busy, imem_req_valid}); end
        tick();
        start = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        n_tests++; if ({busy, imem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL ibr_dropped_start got %b exp 00", {busy, imem_req_valid}); end
        n_tests++; if (pc !== 32'h0040_0020) begin n_fail++; $display("FAIL ibr_pc_reg got %h exp 00400020", pc); end
        tick();
    endtask

    task automatic test_redirect();
        set_pc(32'h0000_0200);
        start_fetch();
        branch_taken = 1'b1; branch_target = 32'h0000_0010;
        @(negedge clk);
        n_tests++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL redir_wait_pc_en got %b exp 0", pc_en); end
        tick();
        branch_target = 32'h0000_0020;
        tick();
        branch_taken = 1'b0;
        sb.push_back('{instr: 32'h0000_0013, npc: 32'h0000_0020});
        capture(32'h0000_0013);
        e = sb.pop_front();
        n_tests++; if (c_npc !== e.npc) begin n_fail++; $display("FAIL redir_last_wins got %h exp %h", c_npc, e.npc); end
        // pending redirect must be gone: the following fetch just advances
        sb.push_back('{instr: 32'h0000_0033, npc: 32'h0000_0024});
        start_fetch();
        capture(32'h0000_0033);
        e = sb.pop_front();
        n_tests++; if (c_npc !== e.npc) begin n_fail++; $display("FAIL redir_cleared got %h exp %h", c_npc, e.npc); end
    endtask

    task automatic test_stall();
        set_pc(32'h0000_0300);
        start = 1'b1;
        tick();
        start = 1'b0; imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; end
            @(negedge clk);
            n_tests++; if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0000_0300}) begin n_fail++; $display("FAIL stall_req_%0d got %b/%h exp 1/00000300", i, imem_req_valid, imem_addr); end
            if (i == 2) begin
                n_tests++; if ({pc_en, instr_valid, instr} !== {2'b00, 32'h0000_0033}) begin n_fail++; $display("FAIL stall_rsp_ignored got %b%b/%h exp 00/00000033", pc_en, instr_valid, instr); end
            end
            tick();
            imem_rsp_valid = 1'b0;
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back('{instr: 32'h0000_1111, npc: 32'h0000_0304});
        capture(32'h0000_1111);
        e = sb.pop_front();
        n_tests++; if ({c_instr, c_npc} !== {e.instr, e.npc}) begin n_fail++; $display("FAIL stall_done got %h/%h exp %h/%h", c_instr, c_npc, e.instr, e.npc); end
        tick();
        @(negedge clk);
        n_tests++; if ({busy, imem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL busy_start_queued got %b exp 00", {busy, imem_req_valid}); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p;
        logic [IW-1:0] d;
        int            gap;
        for (int i = 0; i < 4; i++) begin
            p   = PW'({$urandom} & 32'hFFFF_FFFC);
            d   = IW'($urandom);
            gap = int'($urandom_range(0, 3));
            set_pc(p);
            sb.push_back('{instr: d, npc: p + 32'd4});
            start_fetch();
            repeat (gap) tick();
            capture(d);
            e = sb.pop_front();
            n_tests++; if ({c_iv, c_pe, c_instr, c_npc} !== {2'b11, e.instr, e.npc}) begin n_fail++; $display("FAIL b2b_%0d got %b%b/%h/%h exp 11/%h/%h", i, c_iv, c_pe, c_instr, c_npc, e.instr, e.npc); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        set_pc(32'h0000_0600);
        start_fetch();
        #2 rst_n = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_0BAD;
        #1;
        n_tests++; if ({busy, imem_req_valid, pc_en, instr_valid, fetch_err} !== 5'b0) begin n_fail++; $display("FAIL rmid_outputs got %b exp 00000", {busy, imem_req_valid, pc_en, instr_valid, fetch_err}); end
        n_tests++; if ({instr, imem_addr} !== {32'h0, 32'h0000_0600}) begin n_fail++; $display("FAIL rmid_instr_addr got %h/%h exp 0/00000600", instr, imem_addr); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if ({pc_en, instr_valid, instr} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL rmid_late_rsp got %b%b/%h exp 00/0", pc_en, instr_valid, instr); end
        tick();
        imem_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int err_cnt = 0;
        int err_at  = -1;
        logic pe_at_err = 1'b0;
        set_pc(32'h0000_0700);
        start = 1'b1;
        tick();
        start = 1'b0; imem_req_ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fetch_err === 1'b1) begin err_cnt++; err_at = k; pe_at_err = pc_en; end
            tick();
            imem_req_ready = 1'b0;
        end
`ifdef FETCH_TIMEOUT_EN
        n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL wd_pulses got %0d exp 1", err_cnt); end
        n_tests++; if (err_at !== int'(TO)) begin n_fail++; $display("FAIL wd_cycle got %0d exp %0d", err_at, TO); end
        n_tests++; if (pe_at_err !== 1'b0) begin n_fail++; $display("FAIL wd_pc_en got %b exp 0", pe_at_err); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_idle got busy=%b exp 0", busy); end
`else
        n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL nowd_err got %0d exp 0", err_cnt); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nowd_waiting got busy=%b exp 1", busy); end
`endif
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish (got running, exp done)");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_wrap();
        test_idle_branch();
        test_redirect();
        test_stall();
        test_back_to_back();
        test_reset_mid_fetch();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, the width of the program counter and instruction address.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, the instruction word width.
REQ-003 SHALL have parameter FETCH_TIMEOUT, default 255, the watchdog limit in cycles (used only under REQ-029).
REQ-004 SHALL have clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  in  1  request one instruction fetch, from the main control FSM.
REQ-007 SHALL have branch_taken  in  1  redirect request; branch_target  in  PC_WIDTH  redirect address.
REQ-008 SHALL have pc  in  PC_WIDTH  current program counter value from the PC register.
REQ-009 SHALL have pc_en  out  1 and next_pc  out  PC_WIDTH, which drive the PC register's enable and next-value inputs.
REQ-010 SHALL have imem_req_valid  out  1, imem_req_ready  in  1 and imem_addr  out  PC_WIDTH, forming the instruction-memory request channel.
REQ-011 SHALL have imem_rsp_valid  in  1 and imem_rsp_data  in  INSTR_WIDTH, forming the instruction-memory response channel.
REQ-012 SHALL have instr  out  INSTR_WIDTH (fetched word), instr_valid  out  1 (one-cycle completion pulse), busy  out  1 (state not IDLE) and fetch_err  out  1 (timeout pulse).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, REQ, WAIT.
REQ-014 In IDLE, start=1 with branch_taken=0 SHALL move the FSM to REQ on the next edge.
REQ-015 In REQ: imem_req_valid=1 and imem_addr=pc, both held stable until imem_req_ready=1; the handshake edge SHALL move the FSM to WAIT.
REQ-016 In WAIT, imem_rsp_valid=1 SHALL load imem_rsp_data into instr, pulse instr_valid for one cycle and assert pc_en for the same cycle, then return to IDLE.
REQ-017 On completion, next_pc SHALL equal pc+4, wrapping modulo 2^PC_WIDTH, unless a redirect is pending (REQ-020).
REQ-018 imem_rsp_valid SHALL be ignored in IDLE and REQ.
REQ-019 In IDLE, branch_taken=1 SHALL assert pc_en combinationally with next_pc=branch_target; a start in the same cycle SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-020 branch_taken=1 in REQ or WAIT SHALL latch branch_target into a pending-redirect register; the last such request wins; completion SHALL use it as next_pc and then clear it.
REQ-021 pc_en SHALL be 0 in every cycle not covered by REQ-016 or REQ-019; outside those cycles next_pc SHALL be don't-care but X-free.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 instr SHALL hold its last completed value between fetches.

Reset
REQ-024 rst_n low SHALL force, asynchronously: state=IDLE, instr=0, pending-redirect valid=0 and target=0, timeout counter=0.
REQ-025 During reset the outputs SHALL be: pc_en=0, instr_valid=0, imem_req_valid=0, busy=0, fetch_err=0, imem_addr=pc.
REQ-026 Reset asserted mid-fetch SHALL abandon the transaction, and a response arriving after reset release SHALL be ignored (REQ-018).

Configuration
REQ-027 Macro FETCH_TIMEOUT_EN SHALL compile a watchdog in or out.
REQ-028 Without FETCH_TIMEOUT_EN: fetch_err SHALL be tied to 0, no counter SHALL exist, and the FSM SHALL wait indefinitely.
REQ-029 With FETCH_TIMEOUT_EN: a counter SHALL run in REQ and WAIT and clear on entry to IDLE; on reaching FETCH_TIMEOUT cycles it SHALL pulse fetch_err for one cycle and force IDLE with pc_en=0; any pending redirect SHALL be retained.

Verification
REQ-030 pc=0x00000100, start, ready=1 at once, rsp_valid 2 cycles later with data 0x8C220004 -> instr=0x8C220004, instr_valid and pc_en pulse together, next_pc=0x00000104, busy falls.
REQ-031 pc=0xFFFFFFFC, fetch completes -> next_pc=0x00000000.
REQ-032 IDLE, branch_taken=1 and start=1 with target=0x00400020 -> same-cycle pc_en=1, next_pc=0x00400020, FSM stays IDLE, no request issued.
REQ-033 branch_taken in WAIT with target 0x10, then again with 0x20, then response arrives -> next_pc=0x20 and pending-redirect valid cleared.
REQ-034 imem_req_ready held 0 for 5 cycles -> imem_addr constant throughout; rsp_valid pulsed during REQ -> no effect on instr.
REQ-035 With FETCH_TIMEOUT_EN and FETCH_TIMEOUT=8, no response -> fetch_err pulses once at the 8th busy cycle, FSM returns to IDLE, pc_en=0; rst_n pulsed mid-WAIT -> all outputs take the REQ-025 values immediately.
